spi_bus_master: RTL

- SPI initiator for the PET bus-bridge command protocol; the bridge itself is the SPI target and this block drives it.
- Accepts single read/write requests on a parallel handshake and serializes them as command, data and address bytes over SPI mode 0.
- Waits for the target's completion strobe, then, for reads, clocks one more byte to fetch the result.
- Used by on-FPGA test harnesses and by debug/loader logic that needs bus access through the same path the MCU uses.

---
 rtl/spi_bus_master.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_master.sv
`timescale 1ns/1ps
// SPI mode-0 initiator for the PET bus-bridge: one read/write per request,
// shifted out as command/data/address bytes, then waits for target ready.
module spi_bus_master #(
    parameter int SCLK_HALF = 4,
    parameter int CS_GAP    = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        req_rw_ni,
    input  logic [16:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  rd_data_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_no,
    output logic        spi_tx_o,
    input  logic        spi_rx_i,
    input  logic        spi_ready_i
);

    localparam int M1   = (2 * SCLK_HALF > CS_GAP) ? 2 * SCLK_HALF : CS_GAP;
    localparam int CMAX = (TIMEOUT > M1) ? TIMEOUT : M1;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(2 * SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] GAP_M2  = CW'(CS_GAP - 2);
    localparam logic [CW-1:0] TO_M1   = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, SHIFT, WAIT_RDY, RDBYTE, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    sh_q, sh_d;
    logic [6:0]    rx_q, rx_d;
    logic          rw_q, rw_d;
    logic [16:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    len_q, len_d;
    logic          err_q, err_d;
    logic [16:0]   last_addr_q, last_addr_d;
    logic          last_vld_q, last_vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          tx_q, tx_d;
    logic          rdy_s1, rdy_s2;
    logic          seq;
    logic          byte_last;
    logic [7:0]    tx_bytes [4];

    assign seq = req_rw_ni && last_vld_q
              && (req_addr_i == last_addr_q + 17'd1);
    assign byte_last = ({1'b0, byte_q} == len_q - 3'd1);

    // Byte order differs between writes (data first) and reads
    always_comb begin
        tx_bytes[0] = {len_q, 4'b0000, addr_q[16]};
        tx_bytes[1] = addr_q[15:8];
        tx_bytes[2] = addr_q[7:0];
        tx_bytes[3] = 8'h00;
        if (len_q == 3'd4) begin
            tx_bytes[1] = data_q;
            tx_bytes[2] = addr_q[15:8];
            tx_bytes[3] = addr_q[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        len_d       = len_q;
        err_d       = err_q;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        rd_data_d   = rd_data_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req_i && !busy_q) begin
                    rw_d    = req_rw_ni;
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    len_d   = !req_rw_ni ? 3'd4 : (seq ? 3'd1 : 3'd3);
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SETUP;
                cnt_d   = '0;
                bit_d   = '0;
                byte_d  = '0;
                sh_d    = tx_bytes[0];
            end
            SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_M1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT, RDBYTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    rx_d = {rx_q[5:0], spi_rx_i};
                    if (state_q == RDBYTE && bit_q == 3'd7)
                        rd_data_d = {rx_q, spi_rx_i};
                end
                // MOSI moves on the falling SCLK edge
                if (cnt_q == HALF_M1) begin
                    if (bit_q != 3'd7)
                        sh_d = {sh_q[6:0], 1'b0};
                    else if (state_q == SHIFT && !byte_last)
                        sh_d = tx_bytes[byte_q + 2'd1];
                    else
                        sh_d = 8'h00;
                end
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (state_q == RDBYTE)
                            state_d = GAP;
                        else if (byte_last)
                            state_d = WAIT_RDY;
                        else
                            byte_d = byte_q + 2'd1;
                    end
                end
            end
            WAIT_RDY: begin
                cnt_d = cnt_q + 1'b1;
                if (rdy_s2) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = 8'h00;
                    state_d = rw_q ? RDBYTE : GAP;
                end else if (cnt_q == TO_M1) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_M2) begin
                    done_d  = 1'b1;
                    error_d = err_q;
                end
                if (cnt_q == GAP_M1) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (err_q) begin
                        last_vld_d = 1'b0;
                    end else begin
                        last_addr_d = addr_q;
                        last_vld_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are registered from the next-state view so they stay glitch-free
    always_comb begin
        cs_n_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == GAP);
        sclk_d = ((state_d == SHIFT) || (state_d == RDBYTE))
              && (cnt_d <= HALF_M1);
        tx_d   = sh_d[7] && !cs_n_d;
    end

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rd_data_q   <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            tx_q        <= 1'b0;
            rdy_s1      <= 1'b0;
            rdy_s2      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            len_q       <= len_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rd_data_q   <= rd_data_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            tx_q        <= tx_d;
            rdy_s1      <= spi_ready_i;
            rdy_s2      <= rdy_s1;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign rd_data_o  = rd_data_q;
    assign spi_sclk_o = sclk_q;
    assign spi_cs_no  = cs_n_q;
    assign spi_tx_o   = tx_q;

endmodule
